// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the LC-3b datapath.
// Arbitrates data-memory waits (including two-access LDI/STI), load-use
// interlocks and instruction-fetch misses into per-stage stall/bubble
// controls. Also keeps a one-entry writeback hold register for forwarding
// and a saturating count of stalled cycles.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  ifid_opcode,
  input  logic        ifid_bit5,
  input  logic        ifid_bit11,
  input  logic [2:0]  ifid_src1,
  input  logic [2:0]  ifid_src2,
  input  logic [2:0]  ifid_dest,
  input  logic [3:0]  idex_opcode,
  input  logic [2:0]  idex_dest,
  input  logic        idex_ld_dest,
  input  logic        exme_mem_access,
  input  logic        exme_indirect,
  input  logic        dmem_resp,
  input  logic        imem_resp,
  input  logic        imem_read,
  input  logic        mewb_ld_dest,
  input  logic [2:0]  destmux_out,
  input  logic [15:0] wb_data,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exme,
  output logic        stall_mewb,
  output logic        bubble_ifid,
  output logic        bubble_idex,
  output logic        mem_phase,
  output logic        ld_ptr,
  output logic [19:0] hold_reg_out,
  output logic [15:0] stall_count
);

  // LC-3b opcodes that matter for operand usage
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_SHF = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT1 = 2'd1,
    ST_WAIT2 = 2'd2
  } mem_state_t;

  mem_state_t  state_reg, state_next;
  logic        mem_stall;
  logic        load_use;
  logic        imem_wait;
  logic [2:0]  src_used;
  logic [2:0]  src_field [3];
  logic [2:0]  src_hit;

  // Decode which IF/ID register fields are actually read (src1, src2, dest-as-source)
  always_comb begin
    src_used = 3'b000;
    unique case (ifid_opcode)
      OP_ADD, OP_AND:                          src_used = {1'b0, ~ifid_bit5, 1'b1};
      OP_NOT, OP_SHF, OP_LDB, OP_LDR, OP_LDI,
      OP_JMP:                                  src_used = 3'b001;
      OP_JSR:                                  src_used = {2'b00, ~ifid_bit11};
      OP_STB, OP_STI, OP_STR:                  src_used = 3'b101;
      default:                                 src_used = 3'b000;
    endcase
  end

  assign src_field[0] = ifid_src1;
  assign src_field[1] = ifid_src2;
  assign src_field[2] = ifid_dest;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src_cmp
      assign src_hit[gi] = src_used[gi] && (src_field[gi] == idex_dest);
    end
  endgenerate

  assign load_use  = idex_ld_dest && (idex_opcode inside {OP_LDB, OP_LDR, OP_LDI}) && (|src_hit);
  assign imem_wait = imem_read && !imem_resp;

  // Data-memory wait sequencer: next state plus combinational stall/phase/pointer strobes
  always_comb begin
    state_next = state_reg;
    mem_stall  = 1'b0;
    ld_ptr     = 1'b0;
    mem_phase  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (exme_mem_access) begin
          if (exme_indirect) begin
            mem_stall = 1'b1;
            if (dmem_resp) begin
              ld_ptr     = 1'b1;
              state_next = ST_WAIT2;
            end else begin
              state_next = ST_WAIT1;
            end
          end else if (!dmem_resp) begin
            mem_stall  = 1'b1;
            state_next = ST_WAIT1;
          end
        end
      end
      ST_WAIT1: begin
        if (!dmem_resp) begin
          mem_stall = 1'b1;
        end else if (exme_indirect) begin
          ld_ptr     = 1'b1;
          mem_stall  = 1'b1;
          state_next = ST_WAIT2;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT2: begin
        mem_phase = 1'b1;
        if (dmem_resp) state_next = ST_IDLE;
        else           mem_stall  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall/bubble arbitration: memory wait beats load-use beats fetch miss
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exme  = 1'b0;
    stall_mewb  = 1'b0;
    bubble_ifid = 1'b0;
    bubble_idex = 1'b0;
    if (mem_stall) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      stall_idex = 1'b1;
      stall_exme = 1'b1;
      stall_mewb = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (imem_wait) begin
      stall_pc    = 1'b1;
      bubble_ifid = 1'b1;
    end
  end

  // Memory sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Writeback hold register follows MEM/WB unless that stage is frozen
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         hold_reg_out <= 20'h0;
    else if (!stall_mewb) hold_reg_out <= {mewb_ld_dest, destmux_out, wb_data};
  end

  // Saturating count of cycles in which any stage is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= 16'h0;
    end else if ((stall_pc | stall_ifid | stall_idex | stall_exme | stall_mewb)
                 && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
